// File: rtl/bist_controller.sv
// Logic-BIST sequencer: seeds the LFSR/MISR, runs a programmed number of patterns,
// aligns compaction to CUT latency and compares the final signature with a golden value.
module bist_controller #(
    parameter int N   = 8,
    parameter int CW  = 16,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] num_patterns,
    input  logic [N-1:0]  golden_sig,
    input  logic [N-1:0]  misr_sig,
    output logic          tpg_load,
    output logic          tpg_en,
    output logic          misr_load,
    output logic          misr_en,
    output logic          test_mode,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [CW-1:0] pattern_cnt,
    output logic [2:0]    state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RUN     = 3'd2,
        FLUSH   = 3'd3,
        COMPARE = 3'd4,
        DONE    = 3'd5
    } state_t;

    // A zero-latency CUT still gets one FLUSH cycle when no patterns are applied.
    localparam int FLUSH_LEN = (LAT == 0) ? 1 : LAT;
    localparam int FW = (FLUSH_LEN < 2) ? 1 : $clog2(FLUSH_LEN + 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t        state;
    logic [CW-1:0] num_q;
    logic [N-1:0]  gold_q;
    logic [FW-1:0] flush_cnt;
    logic          active;
    logic          abort_hit;

    // Handshake: start is a one-cycle request accepted only when busy is low
    // (IDLE or DONE); there is no ready, and abort only acts while busy is high.
    assign active    = (state == LOAD) || (state == RUN) ||
                       (state == FLUSH) || (state == COMPARE);
    assign abort_hit = abort && active;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            num_q       <= '0;
            gold_q      <= '0;
            flush_cnt   <= '0;
            tpg_load    <= 1'b0;
            tpg_en      <= 1'b0;
            misr_load   <= 1'b0;
            test_mode   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            pattern_cnt <= '0;
        end else begin
            tpg_load  <= 1'b0;
            misr_load <= 1'b0;
            if (abort_hit) begin
                state     <= IDLE;
                flush_cnt <= '0;
                tpg_en    <= 1'b0;
                test_mode <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b0;
                pass      <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            state       <= LOAD;
                            num_q       <= num_patterns;
                            gold_q      <= golden_sig;
                            tpg_load    <= 1'b1;
                            misr_load   <= 1'b1;
                            test_mode   <= 1'b1;
                            busy        <= 1'b1;
                            done        <= 1'b0;
                            pass        <= 1'b0;
                            pattern_cnt <= '0;
                        end
                    end
                    LOAD: begin
                        if (num_q != '0) begin
                            state       <= RUN;
                            tpg_en      <= 1'b1;
                            pattern_cnt <= CW'(1);
                        end else begin
                            state     <= FLUSH;
                            flush_cnt <= FW'(1);
                        end
                    end
                    RUN: begin
                        // pattern_cnt already counts the pattern applied this cycle.
                        if (pattern_cnt == num_q) begin
                            tpg_en <= 1'b0;
                            if (LAT == 0) begin
                                state <= COMPARE;
                            end else begin
                                state     <= FLUSH;
                                flush_cnt <= FW'(1);
                            end
                        end else if (pattern_cnt != CNT_MAX) begin
                            pattern_cnt <= pattern_cnt + 1'b1;
                        end
                    end
                    FLUSH: begin
                        if (flush_cnt == FW'(FLUSH_LEN)) begin
                            state <= COMPARE;
                        end else begin
                            flush_cnt <= flush_cnt + 1'b1;
                        end
                    end
                    COMPARE: begin
                        state     <= DONE;
                        test_mode <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= (misr_sig == gold_q);
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    generate
        if (LAT == 0) begin : g_nodly
            assign misr_en = tpg_en;
        end else begin : g_dly
            logic [LAT-1:0] dly;

            always_ff @(posedge clk) begin
                if (rst || abort_hit) begin
                    dly <= '0;
                end else begin
                    dly[0] <= tpg_en;
                    for (int i = 1; i < LAT; i++) begin
                        dly[i] <= dly[i-1];
                    end
                end
            end

            assign misr_en = dly[LAT-1];
        end
    endgenerate

endmodule

// File: doc/bist_controller.md
Name: bist_controller

Overview:
- Sequencer for the logic-BIST datapath. Seeds and runs the pattern generator (LFSR), delays the compaction enable to match circuit-under-test (CUT) latency, and stops the MISR after a programmed pattern count.
- Compares the final MISR signature against a golden value and reports done/pass.
- Sits between the CPU/test-access register file and the TPG/CUT/MISR chain.
- misr_load is wired to the MISR seed-load input. tpg_load is wired to the LFSR seed-load input.

Parameters:
- N, 8, signature width in bits (MISR width).
- CW, 16, pattern counter width.
- LAT, 2, CUT latency in cycles from tpg_en to valid MISR input. 0 is legal.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a test. Sampled only in IDLE or DONE.
- abort  in  1  cancel the running test.
- num_patterns  in  CW  number of patterns to apply. Latched on accepted start.
- golden_sig  in  N  expected signature. Latched on accepted start.
- misr_sig  in  N  current MISR contents.
- tpg_load  out  1  one-cycle seed-load pulse to the LFSR.
- tpg_en  out  1  LFSR advance enable.
- misr_load  out  1  one-cycle seed-load pulse to the MISR.
- misr_en  out  1  MISR compaction enable.
- test_mode  out  1  selects BIST patterns at the CUT input mux.
- busy  out  1  test in progress (LOAD through COMPARE).
- done  out  1  result valid.
- pass  out  1  signature match. Valid only when done=1.
- pattern_cnt  out  CW  patterns applied so far in the current or last test.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE. All outputs are 0, pattern_cnt=0, delay line cleared, latched registers cleared. rst has priority over every other input.
- All outputs are registered. States are IDLE, LOAD, RUN, FLUSH, COMPARE, DONE.
- IDLE: all outputs 0. start=1 → LOAD, latch num_patterns and golden_sig.
- LOAD (1 cycle): tpg_load=1, misr_load=1, test_mode=1, busy=1, pattern_cnt←0.
  - Latched num_patterns≠0 → RUN.
  - Latched num_patterns=0 → FLUSH (no patterns applied; signature stays at seed).
- RUN: tpg_en=1, test_mode=1, busy=1. pattern_cnt increments on every RUN cycle.
  - Leave RUN after exactly num_patterns cycles (when pattern_cnt reaches num_patterns). LAT>0 → FLUSH; LAT=0 → COMPARE.
  - pattern_cnt saturates at 2^CW−1 and never wraps.
- misr_en: tpg_en delayed by exactly LAT cycles through a LAT-stage shift register. With LAT=0, misr_en=tpg_en in the same cycle. misr_en is high for exactly num_patterns cycles per test.
- FLUSH: tpg_en=0, test_mode=1, busy=1. Lasts LAT cycles, so the last misr_en pulse drains. With num_patterns=0, FLUSH still lasts LAT cycles (minimum 1 cycle if LAT=0) with misr_en=0. → COMPARE.
- COMPARE (1 cycle): misr_en=0, busy=1. pass←(misr_sig==latched golden_sig). This samples the MISR one cycle after its final update. → DONE.
- DONE: done=1, pass held, busy=0, test_mode=0, pattern_cnt held.
  - start=1 → LOAD. done and pass clear in the cycle LOAD is entered.
- start while busy=1: ignored.
- abort=1 in LOAD/RUN/FLUSH/COMPARE: next state IDLE. All enables 0, delay line flushed to 0, done=0, pass=0, pattern_cnt held.
- abort in IDLE/DONE: no effect.
- abort and start in the same cycle while in DONE: start wins (a new test begins).
- Changes to num_patterns/golden_sig after start: no effect until the next start.

Test Plan:
- Reset: assert rst mid-RUN with num_patterns=10, LAT=2 → next cycle state IDLE, all outputs 0, pattern_cnt=0; a new start afterwards runs normally.
- Nominal: N=8, LAT=2, num_patterns=5, golden_sig set to the model MISR signature.
  - Checks: start at cycle 0 → tpg_load/misr_load high at cycle 1; tpg_en high cycles 2–6; misr_en high cycles 4–8.
  - Result: done=1 at cycle 10, pass=1, pattern_cnt=5.
- Mismatch: same run with golden_sig flipped in bit 0 → done=1, pass=0.
- Boundaries:
  - num_patterns=0 → tpg_en and misr_en never asserted; pass=1 iff golden_sig equals the MISR seed.
  - num_patterns=1 with LAT=0 → exactly one tpg_en cycle coincident with one misr_en cycle.
- Abort: abort on the 3rd RUN cycle → IDLE next cycle, enables drop, done=0, pattern_cnt=3. A start pulse while busy in a separate run is ignored (pattern_cnt continues uninterrupted).
- Restart from DONE: start in DONE with new golden_sig → done/pass clear in the LOAD cycle; second result reflects the new golden value.
